// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: CPU has fixed priority, I/O is guaranteed a slot
// after MAX_WAIT lost cycles. Acks return RD_LAT cycles after each grant.
module mem_port_arbiter #(
  parameter int AW       = 16,
  parameter int DW       = 16,
  parameter int RD_LAT   = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          CpuReq,
  input  logic          CpuWE,
  input  logic [AW-1:0] CpuAddr,
  input  logic [DW-1:0] CpuWData,
  output logic          CpuGrant,
  output logic          CpuAck,
  output logic [DW-1:0] CpuRData,
  output logic          CpuStall,
  input  logic          IoReq,
  input  logic          IoWE,
  input  logic [AW-1:0] IoAddr,
  input  logic [DW-1:0] IoWData,
  output logic          IoGrant,
  output logic          IoAck,
  output logic [DW-1:0] IoRData,
  output logic [AW-1:0] MemAddr,
  output logic [DW-1:0] MemWData,
  output logic          MemWE,
  input  logic [DW-1:0] MemRData,
  output logic          IoStarved
);

  localparam logic [3:0] WaitMax = 4'(MAX_WAIT);

  logic [3:0]        wait_cnt_q, wait_cnt_d;
  logic [RD_LAT-1:0] ack_vld_q, ack_vld_d;
  logic [RD_LAT-1:0] ack_io_q, ack_io_d;
  logic              starved, io_win, cpu_win, ack_vld, ack_io;

  always_comb begin
    starved    = (wait_cnt_q == WaitMax);
    io_win     = Reset & IoReq & (~CpuReq | starved);
    cpu_win    = Reset & CpuReq & ~io_win;
    wait_cnt_d = '0;
    if (IoReq && !io_win) begin
      wait_cnt_d = starved ? wait_cnt_q : wait_cnt_q + 4'd1;
    end
    // Stage 0 captures this cycle's grant; the last stage is the ack slot.
    ack_vld_d = (ack_vld_q << 1) | RD_LAT'(cpu_win | io_win);
    ack_io_d  = (ack_io_q << 1) | RD_LAT'(io_win);
    ack_vld   = Reset & ack_vld_q[RD_LAT-1];
    ack_io    = ack_io_q[RD_LAT-1];
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      wait_cnt_q <= '0;
      ack_vld_q  <= '0;
      ack_io_q   <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      ack_vld_q  <= ack_vld_d;
      ack_io_q   <= ack_io_d;
    end
  end

  // Everything is forced quiet while Reset is low, including the stall.
  assign CpuGrant  = cpu_win;
  assign IoGrant   = io_win;
  assign CpuStall  = Reset & CpuReq & ~cpu_win;
  assign IoStarved = Reset & starved;

  assign CpuAck    = ack_vld & ~ack_io;
  assign IoAck     = ack_vld & ack_io;
  assign CpuRData  = CpuAck ? MemRData : '0;
  assign IoRData   = IoAck ? MemRData : '0;

  assign MemWE     = (cpu_win & CpuWE) | (io_win & IoWE);
  assign MemAddr   = cpu_win ? CpuAddr  : (io_win ? IoAddr  : '0);
  assign MemWData  = cpu_win ? CpuWData : (io_win ? IoWData : '0);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: instance A (RD_LAT=1) and B (RD_LAT=3),
// each with a write-first behavioural memory.
module tb_mem_port_arbiter;

  typedef struct {
    bit          io;
    bit          chk;
    logic [15:0] d;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        cpu_req [2], cpu_we [2], io_req [2], io_we [2];
  logic [15:0] cpu_addr [2], cpu_wdata [2], io_addr [2], io_wdata [2];
  logic        cpu_grant [2], cpu_ack [2], cpu_stall [2];
  logic        io_grant [2], io_ack [2], io_starved [2], mem_we [2];
  logic [15:0] cpu_rdata [2], io_rdata [2], mem_addr [2], mem_wdata [2], mem_rdata [2];

  int    cyc = 0;
  int    n_vec = 0;
  int    n_err = 0;
  string phase = "init";
  exp_t  qa [$];
  exp_t  qb [$];

  mem_port_arbiter #(.AW(16), .DW(16), .RD_LAT(1), .MAX_WAIT(4)) dut_a (
    .Clock(clk), .Reset(rst_n),
    .CpuReq(cpu_req[0]), .CpuWE(cpu_we[0]), .CpuAddr(cpu_addr[0]), .CpuWData(cpu_wdata[0]),
    .CpuGrant(cpu_grant[0]), .CpuAck(cpu_ack[0]), .CpuRData(cpu_rdata[0]), .CpuStall(cpu_stall[0]),
    .IoReq(io_req[0]), .IoWE(io_we[0]), .IoAddr(io_addr[0]), .IoWData(io_wdata[0]),
    .IoGrant(io_grant[0]), .IoAck(io_ack[0]), .IoRData(io_rdata[0]),
    .MemAddr(mem_addr[0]), .MemWData(mem_wdata[0]), .MemWE(mem_we[0]),
    .MemRData(mem_rdata[0]), .IoStarved(io_starved[0])
  );

  mem_port_arbiter #(.AW(16), .DW(16), .RD_LAT(3), .MAX_WAIT(4)) dut_b (
    .Clock(clk), .Reset(rst_n),
    .CpuReq(cpu_req[1]), .CpuWE(cpu_we[1]), .CpuAddr(cpu_addr[1]), .CpuWData(cpu_wdata[1]),
    .CpuGrant(cpu_grant[1]), .CpuAck(cpu_ack[1]), .CpuRData(cpu_rdata[1]), .CpuStall(cpu_stall[1]),
    .IoReq(io_req[1]), .IoWE(io_we[1]), .IoAddr(io_addr[1]), .IoWData(io_wdata[1]),
    .IoGrant(io_grant[1]), .IoAck(io_ack[1]), .IoRData(io_rdata[1]),
    .MemAddr(mem_addr[1]), .MemWData(mem_wdata[1]), .MemWE(mem_we[1]),
    .MemRData(mem_rdata[1]), .IoStarved(io_starved[1])
  );

  // Behavioural memories, write-first, with 1 and 3 cycles of read latency.
  logic [15:0] mem_a [0:65535];
  logic [15:0] mem_b [0:65535];
  logic [15:0] rd_a;
  logic [15:0] rd_b [3];

  always @(posedge clk) begin
    if (mem_we[0]) mem_a[mem_addr[0]] <= mem_wdata[0];
    rd_a <= mem_we[0] ? mem_wdata[0] : mem_a[mem_addr[0]];
    if (mem_we[1]) mem_b[mem_addr[1]] <= mem_wdata[1];
    rd_b[0] <= mem_we[1] ? mem_wdata[1] : mem_b[mem_addr[1]];
    rd_b[1] <= rd_b[0];
    rd_b[2] <= rd_b[1];
  end
  assign mem_rdata[0] = rd_a;
  assign mem_rdata[1] = rd_b[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s cycle %0d: got %h, expected %h", phase, name, cyc, act, exp);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? qa.size() : qb.size();
  endfunction

  function automatic int qdue(input int k);
    if (k == 0) return qa[0].due;
    return qb[0].due;
  endfunction

  task automatic qpop(input int k, output exp_t e);
    if (k == 0) e = qa.pop_front();
    else        e = qb.pop_front();
  endtask

  // One clock of stimulus on instance k with hand-computed grant expectations.
  task automatic step(input int k, input bit rst,
                      input bit cr, input bit cw, input logic [15:0] ca, input logic [15:0] cd,
                      input bit ir, input bit iw, input logic [15:0] ia, input logic [15:0] id,
                      input bit eg_c, input bit eg_i, input bit e_st,
                      input bit push, input bit chk_d, input logic [15:0] e_d);
    exp_t        e;
    logic [32:0] exp_mem;
    @(posedge clk);
    #1;
    rst_n = rst;
    for (int j = 0; j < 2; j++) begin
      cpu_req[j] = 1'b0; cpu_we[j] = 1'b0; io_req[j] = 1'b0; io_we[j] = 1'b0;
    end
    cpu_req[k] = cr; cpu_we[k] = cw; cpu_addr[k] = ca; cpu_wdata[k] = cd;
    io_req[k]  = ir; io_we[k]  = iw; io_addr[k]  = ia; io_wdata[k]  = id;
    #3;
    check($sformatf("grant_stall_starved[%0d]", k),
          64'({cpu_grant[k], io_grant[k], cpu_stall[k], io_starved[k]}),
          64'({eg_c, eg_i, rst & cr & ~eg_c, e_st}));
    exp_mem = eg_c ? {cw, ca, cd} : (eg_i ? {iw, ia, id} : 33'h0);
    check($sformatf("mem_we_addr_wdata[%0d]", k),
          64'({mem_we[k], mem_addr[k], mem_wdata[k]}), 64'(exp_mem));
    if (!rst) begin
      check($sformatf("reset_ack_rdata[%0d]", k),
            64'({cpu_ack[k], io_ack[k], cpu_rdata[k], io_rdata[k]}), 64'h0);
    end
    if (push && (eg_c || eg_i)) begin
      e.io  = eg_i;
      e.chk = chk_d;
      e.d   = e_d;
      e.due = cyc + ((k == 0) ? 1 : 3);
      if (k == 0) qa.push_back(e);
      else        qb.push_back(e);
    end
  endtask

  task automatic idle(input int k, input bit rst);
    step(k, rst, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0,
         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
  endtask

  task automatic both(input int k, input bit e_io, input bit e_st, input bit push);
    step(k, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h0, 1'b1, 1'b0, 16'h0030, 16'h0,
         !e_io, e_io, e_st, push, 1'b1, e_io ? 16'h5678 : 16'h1234);
  endtask

  task automatic cpu_op(input int k, input bit we, input logic [15:0] a, input logic [15:0] d,
                        input bit chk_d, input logic [15:0] e_d);
    step(k, 1'b1, 1'b1, we, a, d, 1'b0, 1'b0, 16'h0, 16'h0,
         1'b1, 1'b0, 1'b0, 1'b1, chk_d, e_d);
  endtask

  task automatic io_op(input int k, input bit we, input logic [15:0] a, input logic [15:0] d,
                       input bit chk_d, input logic [15:0] e_d);
    step(k, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, we, a, d,
         1'b0, 1'b1, 1'b0, 1'b1, chk_d, e_d);
  endtask

  // Monitor: pops the scoreboard whenever an instance raises an ack.
  task automatic mon(input int k, input logic ca, input logic ia,
                     input logic [15:0] cr, input logic [15:0] ir);
    exp_t e;
    while (qsize(k) > 0 && qdue(k) < cyc) begin
      qpop(k, e);
      n_vec++;
      n_err++;
      $display("FAIL %s/missing_ack[%0d]: got no ack by cycle %0d, expected %s ack at cycle %0d",
               phase, k, cyc, e.io ? "io" : "cpu", e.due);
    end
    if (ca === 1'b1 || ia === 1'b1) begin
      n_vec++;
      if (ca === 1'b1 && ia === 1'b1) begin
        n_err++;
        $display("FAIL %s/dual_ack[%0d] cycle %0d: got CpuAck=1 IoAck=1, expected one ack", phase, k, cyc);
      end else if (qsize(k) == 0) begin
        n_err++;
        $display("FAIL %s/unexpected_ack[%0d] cycle %0d: got CpuAck=%b IoAck=%b, expected none",
                 phase, k, cyc, ca, ia);
      end else begin
        qpop(k, e);
        if (e.due != cyc || e.io != ia || (e.chk && ((ia ? ir : cr) !== e.d)) ||
            ((ia ? cr : ir) !== 16'h0)) begin
          n_err++;
          $display("FAIL %s/ack[%0d] cycle %0d: got io=%b cpu_rdata=%h io_rdata=%h, expected io=%b data=%h at cycle %0d",
                   phase, k, cyc, ia, cr, ir, e.io, e.d, e.due);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, cpu_ack[0], io_ack[0], cpu_rdata[0], io_rdata[0]);
    mon(1, cpu_ack[1], io_ack[1], cpu_rdata[1], io_rdata[1]);
  end

  initial begin
    for (int j = 0; j < 2; j++) begin
      cpu_req[j] = 1'b0; cpu_we[j] = 1'b0; cpu_addr[j] = 16'h0; cpu_wdata[j] = 16'h0;
      io_req[j]  = 1'b0; io_we[j]  = 1'b0; io_addr[j]  = 16'h0; io_wdata[j]  = 16'h0;
    end
    mem_a[16'h0020] = 16'h1234;
    mem_a[16'h0030] = 16'h5678;
    mem_a[16'h0031] = 16'h7777;
    for (int i = 0; i < 8; i++) begin
      mem_a[16'h0100 + 16'(i)] = 16'hA000 + 16'(i);
      mem_b[16'h0040 + 16'(i)] = 16'hC000 + 16'(i);
      mem_b[16'h0080 + 16'(i)] = 16'hD000 + 16'(i);
    end

    phase = "reset";
    for (int i = 0; i < 3; i++) begin
      step(0, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0, 1'b1, 1'b0, 16'h0030, 16'h0,
           1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    end
    phase = "release";
    cpu_op(0, 1'b0, 16'h0020, 16'h0, 1'b1, 16'h1234);
    idle(0, 1'b1);

    phase = "cpu_wr_rd";
    cpu_op(0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, 16'h0);
    cpu_op(0, 1'b0, 16'h0010, 16'h0, 1'b1, 16'hBEEF);
    idle(0, 1'b1);

    phase = "starve";
    for (int i = 0; i < 10; i++) both(0, (i % 5) == 4, (i % 5) == 4, 1'b1);
    idle(0, 1'b1);

    phase = "withdraw";
    for (int i = 0; i < 4; i++) both(0, 1'b0, 1'b0, 1'b1);
    step(0, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h0, 1'b0, 1'b0, 16'h0, 16'h0,
         1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h1234);
    both(0, 1'b0, 1'b0, 1'b1);
    idle(0, 1'b1);

    phase = "io_burst";
    for (int i = 0; i < 8; i++) io_op(0, 1'b0, 16'h0100 + 16'(i), 16'h0, 1'b1, 16'hA000 + 16'(i));
    idle(0, 1'b1);

    phase = "reset_mid_io";
    step(0, 1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0031, 16'h0,
         1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
    idle(0, 1'b0);
    idle(0, 1'b1);

    phase = "reset_clears_wait";
    both(0, 1'b0, 1'b0, 1'b1);
    both(0, 1'b0, 1'b0, 1'b1);
    both(0, 1'b0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b1, 1'b0, 16'h0020, 16'h0, 1'b1, 1'b0, 16'h0030, 16'h0,
         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    for (int i = 0; i < 5; i++) both(0, i == 4, i == 4, 1'b1);
    idle(0, 1'b1);

    phase = "rdlat3_alt";
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) cpu_op(1, 1'b0, 16'h0040 + 16'(i), 16'h0, 1'b1, 16'hC000 + 16'(i));
      else            io_op(1, 1'b0, 16'h0080 + 16'(i), 16'h0, 1'b1, 16'hD000 + 16'(i));
    end
    for (int i = 0; i < 5; i++) idle(1, 1'b1);

    phase = "drain";
    @(negedge clk);
    #1;
    check("scoreboard_empty_a", 64'(qa.size()), 64'h0);
    check("scoreboard_empty_b", 64'(qb.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
